// File: rtl/systolic_sequencer.sv
// Control sequencer for one NxN systolic matrix-multiply pass:
// operand load, skewed feed of 2N-1 steps, drain, then a one-cycle done pulse.
module systolic_sequencer #(
  parameter int unsigned N     = 4,
  parameter int unsigned DRAIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       load,
  output logic [5:0] count,
  output logic       acc_clr,
  output logic       pe_en,
  output logic       zero_feed,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned FEED_LEN = 2 * N - 1;
  localparam int unsigned DRN_W    = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [DRN_W-1:0]   r_drain;
  logic               r_load;
  logic               r_acc_clr;
  logic               r_pe_en;
  logic               r_zero_feed;
  logic               r_done;

  logic               w_feeding;
  logic               w_draining;

  assign w_feeding  = (r_state == S_FEED);
  assign w_draining = (r_state == S_DRAIN);

  // Pass sequencing; abort from any busy state returns to IDLE at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_drain     <= '0;
      r_load      <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_pe_en     <= 1'b0;
      r_zero_feed <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_load      <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_done      <= 1'b0;
      // PE enable and edge-zeroing trail the feeder by one cycle of latency
      r_pe_en     <= (w_feeding || w_draining) && !abort;
      r_zero_feed <= w_draining && !abort;

      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state   <= S_LOAD;
            r_load    <= 1'b1;
            r_acc_clr <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_FEED;
            r_count <= CNT_W'(1);
          end
        end
        S_FEED: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (r_count == CNT_W'(FEED_LEN)) begin
            r_state <= S_DRAIN;
            r_count <= '0;
            r_drain <= '0;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_drain == DRN_W'(DRAIN - 1)) begin
            r_state <= S_FIN;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= !abort;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign load      = r_load;
  assign acc_clr   = r_acc_clr;
  assign count     = r_count;
  assign pe_en     = r_pe_en;
  assign zero_feed = r_zero_feed;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares. Instance A uses defaults, instance B is N=2, DRAIN=1.
module tb_systolic_sequencer;

  typedef struct packed {
    logic       load;
    logic       acc_clr;
    logic [5:0] count;
    logic       pe_en;
    logic       zero_feed;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
    int    cyc;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       start_b;
  logic       abort_b;

  logic       a_load, a_acc_clr, a_pe_en, a_zero_feed, a_busy, a_done;
  logic [5:0] a_count;
  logic       b_load, b_acc_clr, b_pe_en, b_zero_feed, b_busy, b_done;
  logic [5:0] b_count;

  obs_t obs_a;
  obs_t obs_b;

  ent_t qa[$];
  ent_t qb[$];

  int   checks;
  int   errors;
  int   mon_cyc;
  logic finish_req;

  always #5 clk = ~clk;

  systolic_sequencer u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .load      (a_load),
    .count     (a_count),
    .acc_clr   (a_acc_clr),
    .pe_en     (a_pe_en),
    .zero_feed (a_zero_feed),
    .busy      (a_busy),
    .done      (a_done)
  );

  systolic_sequencer #(.N(2), .DRAIN(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .load      (b_load),
    .count     (b_count),
    .acc_clr   (b_acc_clr),
    .pe_en     (b_pe_en),
    .zero_feed (b_zero_feed),
    .busy      (b_busy),
    .done      (b_done)
  );

  assign obs_a = {a_load, a_acc_clr, a_count, a_pe_en, a_zero_feed, a_busy, a_done};
  assign obs_b = {b_load, b_acc_clr, b_count, b_pe_en, b_zero_feed, b_busy, b_done};

  // Reference waveform of one pass whose start is sampled at relative cycle 0.
  function automatic obs_t wave(input int k, input int n, input int d);
    obs_t o;
    o = '0;
    if (k == 1) begin
      o.load    = 1'b1;
      o.acc_clr = 1'b1;
    end
    if (k >= 2 && k <= 2 * n)             o.count     = 6'(k - 1);
    if (k >= 3 && k <= 2 * n + d + 1)     o.pe_en     = 1'b1;
    if (k >= 2 * n + 2 && k <= 2 * n + d + 1) o.zero_feed = 1'b1;
    if (k >= 1 && k <= 2 * n + d + 1)     o.busy      = 1'b1;
    if (k == 2 * n + d + 2)               o.done      = 1'b1;
    return o;
  endfunction

  function automatic obs_t merge(input obs_t x, input obs_t y);
    return obs_t'(x | y);
  endfunction

  task automatic drive(input logic s, input logic a, input logic r, input obs_t e,
                       input string tag, input int k);
    start = s;
    abort = a;
    rst_n = r;
    qa.push_back('{exp: e, tag: tag, cyc: k});
    @(posedge clk);
    #1;
  endtask

  function automatic void check_one(input obs_t got, input ent_t e, input string who);
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("FAIL %s_%s cyc%0d: got load=%b clr=%b cnt=%0d pe=%b zf=%b busy=%b done=%b, want load=%b clr=%b cnt=%0d pe=%b zf=%b busy=%b done=%b",
               who, e.tag, e.cyc, got.load, got.acc_clr, got.count, got.pe_en, got.zero_feed,
               got.busy, got.done, e.exp.load, e.exp.acc_clr, e.exp.count, e.exp.pe_en,
               e.exp.zero_feed, e.exp.busy, e.exp.done);
    end
  endfunction

  // Monitor: compares every cycle that has a queued expectation, owns all counters.
  always @(negedge clk) begin
    ent_t e;
    mon_cyc++;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check_one(obs_a, e, "A");
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check_one(obs_b, e, "B");
    end
    if (finish_req) begin
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
        errors++;
        $display("FAIL drain_queue: got %0d/%0d entries left, want 0/0", qa.size(), qb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (mon_cyc > 4000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles without completion, want <= 4000", mon_cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    mon_cyc    = 0;
    finish_req = 1'b0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    start_b    = 1'b0;
    abort_b    = 1'b0;
    @(posedge clk);
    #1;

    // Reset state on both instances
    for (int k = 0; k < 2; k++) begin
      qb.push_back('{exp: '0, tag: "reset", cyc: k});
      drive(1'b1, 1'b0, 1'b0, '0, "reset", k);
    end
    for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b1, '0, "idle", k);

    // Single pass, defaults
    for (int k = 0; k <= 16; k++)
      drive(k == 0, 1'b0, 1'b1, wave(k, 4, 4), "basic", k);

    // Starts while busy ignored; abort during the done cycle leaves done intact
    for (int k = 0; k <= 16; k++)
      drive(k == 0 || k == 5 || k == 9, k == 14, 1'b1, wave(k, 4, 4), "busy_start", k);

    // Start held high: back-to-back passes with LOAD right after each done
    for (int k = 0; k <= 44; k++)
      drive(k <= 28, 1'b0, 1'b1,
            merge(merge(wave(k, 4, 4), wave(k - 14, 4, 4)), wave(k - 28, 4, 4)), "b2b", k);

    // Abort mid-feed, then a fresh pass
    for (int k = 0; k <= 22; k++) begin
      obs_t e;
      if (k <= 4)      e = wave(k, 4, 4);
      else if (k == 5) e = '0;
      else             e = wave(k - 6, 4, 4);
      drive(k == 0 || k == 6, k == 4, 1'b1, e, "abort", k);
    end

    // start and abort together in IDLE: nothing happens
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, 1'b1, '0, "start_abort", k);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, '0, "post_sa", k);

    // Reset asserted mid-DRAIN, then a normal pass
    for (int k = 0; k <= 16; k++) begin
      if (k < 10)      drive(k == 0, 1'b0, 1'b1, wave(k, 4, 4), "pre_rst", k);
      else if (k < 12) drive(1'b0, 1'b0, 1'b0, '0, "mid_rst", k);
      else             drive(1'b0, 1'b0, 1'b1, '0, "post_rst", k);
    end
    for (int k = 0; k <= 15; k++)
      drive(k == 0, 1'b0, 1'b1, wave(k, 4, 4), "after_rst", k);

    // Small build N=2, DRAIN=1
    for (int k = 0; k <= 9; k++) begin
      start_b = (k == 0);
      qb.push_back('{exp: wave(k, 2, 1), tag: "n2_d1", cyc: k});
      drive(1'b0, 1'b0, 1'b1, '0, "a_quiet", k);
    end

    drive(1'b0, 1'b0, 1'b1, '0, "tail", 0);
    finish_req = 1'b1;
  end

endmodule
